muldiv_sequencer: RTL and testbench

Sequencer that owns the multiplier and divider and the HI/LO write-back path. The control unit hands it a single MULT or DIV request. The block then latches the operands, pulses the selected unit's start, and waits for that unit's ready. It finishes by issuing one HI/LO write, or a divide-by-zero or timeout exception. It sits between `controlUnit`, the `multiplier`/`divider` pair and the HI/LO registers, and replaces the direct `A_out`/`B_out`/`HI_in`/`LO_in` wiring.

---
 rtl/muldiv_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - MULT/DIV request sequencer owning the multiplier/divider handshake and HI/LO write-back
//
// Accepts one MULT or DIV request from the control unit and latches the operands.
// It then pulses the selected unit's start and waits for that unit's ready.
// It finishes with a single HI/LO write, a divide-by-zero exception, or (optionally) a timeout exception.
//
// Optional feature macro: MULDIV_TIMEOUT_EN
//   defined   : WAIT is bounded to TIMEOUT_CYCLES cycles, then TIMEOUT raises exc_timeout
//   undefined : WAIT waits indefinitely, exc_timeout is tied low
//
// Ports:
//   clk, reset                      clock (rising edge), asynchronous active-high reset
//   req_valid, req_op, req_ready    request handshake; req_op 0 = MULT, 1 = DIV
//   a, b                            request operands (rs, rt)
//   op_a, op_b                      latched operands driven to both units
//   mult_start, div_start           one-cycle unit start pulses
//   mult_ready, div_ready           unit completion inputs
//   mult_hi/lo, div_hi/lo, div_zero unit results; div_zero valid with div_ready
//   hi_out, lo_out, hi_wr, lo_wr    registered results and HI/LO load enables
//   done, exc_div_zero, exc_timeout one-cycle completion / exception pulses
//   busy                            high whenever not IDLE
module muldiv_sequencer #(
   parameter int WIDTH          = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_op,
   output logic             req_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             mult_start,
   output logic             div_start,
   input  logic             mult_ready,
   input  logic             div_ready,
   input  logic [WIDTH-1:0] mult_hi,
   input  logic [WIDTH-1:0] mult_lo,
   input  logic [WIDTH-1:0] div_hi,
   input  logic [WIDTH-1:0] div_lo,
   input  logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             hi_wr,
   output logic             lo_wr,
   output logic             done,
   output logic             exc_div_zero,
   output logic             exc_timeout,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LAUNCH = 3'd1,
      S_WAIT   = 3'd2,
      S_WRITE  = 3'd3,
`ifdef MULDIV_TIMEOUT_EN
      S_FAULT   = 3'd4,
      S_TIMEOUT = 3'd5
`else
      S_FAULT  = 3'd4
`endif
   } state_t;

   state_t state;
   state_t state_next;

   logic op_div;       // latched request type, 1 = DIV
   logic accept;
   logic unit_ready;   // ready of the selected unit only
   logic unit_fault;   // selected unit reports divide-by-zero
   logic capture;

   assign accept     = (state == S_IDLE) && req_valid;
   assign unit_ready = op_div ? div_ready : mult_ready;
   assign unit_fault = op_div && div_zero;
   assign capture    = (state == S_WAIT) && unit_ready && !unit_fault;

`ifdef MULDIV_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] wait_cnt;

   // Counts WAIT cycles already spent without ready; cleared in LAUNCH so it
   // reads zero on the first WAIT cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (state == S_LAUNCH) begin
         wait_cnt <= '0;
      end else if ((state == S_WAIT) && !unit_ready) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         op_div <= 1'b0;
         op_a   <= '0;
         op_b   <= '0;
         hi_out <= '0;
         lo_out <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            op_div <= req_op;
            op_a   <= a;
            op_b   <= b;
         end
         if (capture) begin
            hi_out <= op_div ? div_hi : mult_hi;
            lo_out <= op_div ? div_lo : mult_lo;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               // A zero divisor is caught here so the divider is never started.
               if (req_op && (b == '0)) begin
                  state_next = S_FAULT;
               end else begin
                  state_next = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            state_next = S_WAIT;
         end
         S_WAIT: begin
            // Ready takes priority over an expiring timeout.
            if (unit_ready) begin
               state_next = unit_fault ? S_FAULT : S_WRITE;
`ifdef MULDIV_TIMEOUT_EN
            end else if (wait_cnt == CNT_LAST) begin
               state_next = S_TIMEOUT;
`endif
            end
         end
         S_WRITE: begin
            state_next = S_IDLE;
         end
         S_FAULT: begin
            state_next = S_IDLE;
         end
`ifdef MULDIV_TIMEOUT_EN
         S_TIMEOUT: begin
            state_next = S_IDLE;
         end
`endif
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // All control outputs decode from the state register (plus the latched op),
   // so nothing combinationally follows an input.
   assign req_ready    = (state == S_IDLE);
   assign busy         = (state != S_IDLE);
   assign mult_start   = (state == S_LAUNCH) && !op_div;
   assign div_start    = (state == S_LAUNCH) && op_div;
   assign hi_wr        = (state == S_WRITE);
   assign lo_wr        = (state == S_WRITE);
   assign exc_div_zero = (state == S_FAULT);

`ifdef MULDIV_TIMEOUT_EN
   assign exc_timeout = (state == S_TIMEOUT);
   assign done        = (state == S_WRITE) || (state == S_FAULT) || (state == S_TIMEOUT);
`else
   assign exc_timeout = 1'b0;
   assign done        = (state == S_WRITE) || (state == S_FAULT);
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

   localparam int W = 32;
   localparam logic [W-1:0] JUNK = 32'hdead_beef;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req_valid = 1'b0;
   logic         req_op = 1'b0;
   logic         req_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] op_a, op_b;
   logic         mult_start, div_start;
   logic         mult_ready = 1'b0;
   logic         div_ready = 1'b0;
   logic [W-1:0] mult_hi = '0, mult_lo = '0, div_hi = '0, div_lo = '0;
   logic         div_zero = 1'b0;
   logic [W-1:0] hi_out, lo_out;
   logic         hi_wr, lo_wr, done, exc_div_zero, exc_timeout, busy;

   muldiv_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_ready    (req_ready),
      .a            (a),
      .b            (b),
      .op_a         (op_a),
      .op_b         (op_b),
      .mult_start   (mult_start),
      .div_start    (div_start),
      .mult_ready   (mult_ready),
      .div_ready    (div_ready),
      .mult_hi      (mult_hi),
      .mult_lo      (mult_lo),
      .div_hi       (div_hi),
      .div_lo       (div_lo),
      .div_zero     (div_zero),
      .hi_out       (hi_out),
      .lo_out       (lo_out),
      .hi_wr        (hi_wr),
      .lo_wr        (lo_wr),
      .done         (done),
      .exc_div_zero (exc_div_zero),
      .exc_timeout  (exc_timeout),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Results of the last wait_done call.
   int           r_done_cyc, r_ms, r_ds, r_wr, r_lw, r_done, r_ez, r_et;
   logic [W-1:0] r_hi, r_lo, r_a, r_b;
   logic         r_busy_after, r_ready_after;

   // Replacement request loaded instead of dropping req_valid after accept.
   logic         nxt_en = 1'b0;
   logic         nxt_op = 1'b0;
   logic [W-1:0] nxt_a = '0, nxt_b = '0;

   task automatic issue(input logic op, input logic [W-1:0] av, input logic [W-1:0] bv);
      req_op    = op;
      a         = av;
      b         = bv;
      req_valid = 1'b1;
   endtask

   // Cycle 1 is the cycle after the accepting edge. The selected unit returns
   // ready in WAIT cycle k (overall cycle k+1); k <= 0 means never.
   task automatic wait_done(input logic op, input int k, input logic [W-1:0] rh,
                            input logic [W-1:0] rl, input logic rz, input logic spur);
      r_done_cyc = -1;
      r_ms = 0; r_ds = 0; r_wr = 0; r_lw = 0; r_done = 0; r_ez = 0; r_et = 0;
      mult_hi = op ? JUNK : rh;
      mult_lo = op ? JUNK : rl;
      div_hi  = op ? rh : JUNK;
      div_lo  = op ? rl : JUNK;
      for (int cyc = 1; cyc <= 100 && r_done_cyc < 0; cyc++) begin
         @(posedge clk); #1;
         mult_ready = 1'b0;
         div_ready  = 1'b0;
         div_zero   = 1'b0;
         if (cyc == 1) begin
            if (nxt_en) begin
               req_op = nxt_op; a = nxt_a; b = nxt_b; nxt_en = 1'b0;
            end else begin
               req_valid = 1'b0;
            end
         end
         r_ms   += int'(mult_start);
         r_ds   += int'(div_start);
         r_wr   += int'(hi_wr);
         r_lw   += int'(lo_wr);
         r_done += int'(done);
         r_ez   += int'(exc_div_zero);
         r_et   += int'(exc_timeout);
         if (done) begin
            r_done_cyc = cyc;
            r_hi = hi_out; r_lo = lo_out; r_a = op_a; r_b = op_b;
         end
         if (k > 0 && cyc == k + 1) begin
            if (op) begin div_ready = 1'b1; div_zero = rz; end
            else mult_ready = 1'b1;
         end
         if (spur && cyc == 2) mult_ready = 1'b1;
      end
      if (r_done_cyc < 0) check("done_budget", 0, 1);
      @(posedge clk); #1;
      mult_ready = 1'b0; div_ready = 1'b0; div_zero = 1'b0;
      r_done       += int'(done);
      r_wr         += int'(hi_wr);
      r_busy_after  = busy;
      r_ready_after = req_ready;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_ready", req_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_pulses", {mult_start, div_start, hi_wr, lo_wr, done, exc_div_zero, exc_timeout}, 0);
      check("rst_regs", {op_a, op_b} | {hi_out, lo_out}, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // MULT 7x6, ready in WAIT cycle 5
      issue(1'b0, 7, 6);
      wait_done(1'b0, 5, 0, 42, 1'b0, 1'b0);
      check("m1_done_cyc", r_done_cyc, 7);
      check("m1_mstart", r_ms, 1);
      check("m1_dstart", r_ds, 0);
      check("m1_hi_wr", r_wr, 1);
      check("m1_lo_wr", r_lw, 1);
      check("m1_done_cnt", r_done, 1);
      check("m1_hi", r_hi, 0);
      check("m1_lo", r_lo, 42);
      check("m1_busy_after", r_busy_after, 0);
      check("m1_ops", {op_a, op_b}, {32'd7, 32'd6});
      check("m1_no_tmo", r_et, 0);

      // DIV 17/5 with spurious mult_ready in WAIT
      issue(1'b1, 17, 5);
      wait_done(1'b1, 3, 2, 3, 1'b0, 1'b1);
      check("d1_done_cyc", r_done_cyc, 5);
      check("d1_dstart", r_ds, 1);
      check("d1_mstart", r_ms, 0);
      check("d1_wr", r_wr, 1);
      check("d1_hilo", {r_hi, r_lo}, {32'd2, 32'd3});

      // DIV 9/0: fault straight from IDLE
      issue(1'b1, 9, 0);
      wait_done(1'b1, 0, 0, 0, 1'b0, 1'b0);
      check("dz_done_cyc", r_done_cyc, 1);
      check("dz_dstart", r_ds, 0);
      check("dz_exc", r_ez, 1);
      check("dz_wr", r_wr, 0);
      check("dz_retain", {hi_out, lo_out}, {32'd2, 32'd3});

      // Divider itself flags zero on ready
      issue(1'b1, 8, 4);
      wait_done(1'b1, 2, 0, 0, 1'b1, 1'b0);
      check("dzu_done_cyc", r_done_cyc, 4);
      check("dzu_exc", r_ez, 1);
      check("dzu_wr", r_wr, 0);
      check("dzu_dstart", r_ds, 1);

      // Minimum latency
      issue(1'b0, 2, 2);
      wait_done(1'b0, 1, 0, 4, 1'b0, 1'b0);
      check("min_done_cyc", r_done_cyc, 3);
      check("min_lo", r_lo, 4);

      // Back-to-back with request held during busy
      issue(1'b1, 100, 7);
      nxt_en = 1'b1; nxt_op = 1'b0; nxt_a = 3; nxt_b = 3;
      wait_done(1'b1, 3, 2, 14, 1'b0, 1'b0);
      check("bb1_done_cyc", r_done_cyc, 5);
      check("bb1_hilo", {r_hi, r_lo}, {32'd2, 32'd14});
      check("bb1_op_a_stable", r_a, 100);
      check("bb1_dstart", r_ds, 1);
      check("bb1_mstart", r_ms, 0);
      check("bb_idle_ready", r_ready_after, 1);
      wait_done(1'b0, 2, 0, 9, 1'b0, 1'b0);
      check("bb2_done_cyc", r_done_cyc, 4);
      check("bb2_lo", r_lo, 9);
      check("bb2_ops", {r_a, r_b}, {32'd3, 32'd3});
      check("bb2_mstart", r_ms, 1);
      check("bb2_dstart", r_ds, 0);

      // Reset during WAIT, late ready afterwards
      issue(1'b0, 5, 5);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("rw_busy_pre", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("rw_busy", busy, 0);
      check("rw_ready", req_ready, 1);
      check("rw_regs", {op_a, hi_out, lo_out}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      mult_ready = 1'b1;
      begin
         int wr_cnt = 0, dn_cnt = 0, bz_cnt = 0;
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mult_ready = 1'b0;
            wr_cnt += int'(hi_wr);
            dn_cnt += int'(done);
            bz_cnt += int'(busy);
         end
         check("rw_no_wr", wr_cnt, 0);
         check("rw_no_done", dn_cnt, 0);
         check("rw_idle", bz_cnt, 0);
         check("rw_lo", lo_out, 0);
      end

`ifdef MULDIV_TIMEOUT_EN
      // Unit never readies: TIMEOUT after 8 WAIT cycles
      issue(1'b0, 1, 1);
      wait_done(1'b0, 0, 0, 0, 1'b0, 1'b0);
      check("to_done_cyc", r_done_cyc, 10);
      check("to_exc", r_et, 1);
      check("to_wr", r_wr, 0);
      // Ready in the 8th WAIT cycle wins
      issue(1'b0, 1, 1);
      wait_done(1'b0, 8, 0, 1, 1'b0, 1'b0);
      check("tl_done_cyc", r_done_cyc, 10);
      check("tl_exc", r_et, 0);
      check("tl_wr", r_wr, 1);
      check("tl_lo", r_lo, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
